fsm_hello_tx: RTL and testbench



---
 rtl/fsm_hello_pkg.sv | 36 +++
 rtl/hello_gap_cnt.sv | 27 ++
 rtl/fsm_hello_tx.sv | 117 +++++++++++
 tb/tb_fsm_hello_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_hello_pkg.sv
// Shared definitions for the "Hello" transmitter and detector: ASCII bytes,
// one-hot state encoding and small state-decode helpers.
package fsm_hello_pkg;

  localparam logic [7:0] CH_H = 8'h48;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_L = 8'h6C;
  localparam logic [7:0] CH_O = 8'h6F;
  localparam logic [39:0] HELLO_WORD = {CH_H, CH_E, CH_L, CH_L, CH_O};

  typedef enum logic [6:0] {
    ST_IDLE    = 7'b0000001,
    ST_SEND_H  = 7'b0000010,
    ST_SEND_E  = 7'b0000100,
    ST_SEND_L1 = 7'b0001000,
    ST_SEND_L2 = 7'b0010000,
    ST_SEND_O  = 7'b0100000,
    ST_GAP     = 7'b1000000
  } state_t;

  function automatic logic is_send(input state_t s);
    return (s == ST_SEND_H) || (s == ST_SEND_E) || (s == ST_SEND_L1) ||
           (s == ST_SEND_L2) || (s == ST_SEND_O);
  endfunction

  function automatic logic [7:0] char_of(input state_t s);
    case (s)
      ST_SEND_H:               return CH_H;
      ST_SEND_E:               return CH_E;
      ST_SEND_L1, ST_SEND_L2:  return CH_L;
      ST_SEND_O:               return CH_O;
      default:                 return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/hello_gap_cnt.sv
// Loadable down-counter timing the idle gap between transmitted bytes.
module hello_gap_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fsm_hello_tx.sv
// Emits "Hello" a programmable number of times on a valid/ready byte stream,
// with an optional fixed idle gap after every accepted byte.
module fsm_hello_tx
  import fsm_hello_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int REPEAT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [REPEAT_W-1:0] repeat_n,
  output logic [7:0]          data,
  output logic                valid,
  input  logic                ready,
  output logic                busy,
  output logic                done
);

  // Counter holds GAP_CYCLES-1 on entry so GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  state_t state_reg, state_next, ret_reg, ret_next, target;
  logic [REPEAT_W-1:0] rep_reg, rep_next, cnt_reg, cnt_next, cnt_inc;
  logic [7:0] data_next;
  logic valid_next, busy_next, done_next;
  logic adv, gap_load, gap_zero;
  logic xfer;

  assign xfer = valid && ready;

  hello_gap_cnt #(.W(8)) u_gap (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (state_reg == ST_GAP),
    .zero     (gap_zero)
  );

  always_comb begin
    state_next = state_reg;
    ret_next   = ret_reg;
    rep_next   = rep_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    gap_load   = 1'b0;
    adv        = 1'b0;
    target     = ST_IDLE;
    cnt_inc    = cnt_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          rep_next   = (repeat_n == '0) ? REPEAT_W'(1) : repeat_n;
          cnt_next   = '0;
          state_next = ST_SEND_H;
        end
      end
      ST_SEND_H:  begin adv = xfer; target = ST_SEND_E;  end
      ST_SEND_E:  begin adv = xfer; target = ST_SEND_L1; end
      ST_SEND_L1: begin adv = xfer; target = ST_SEND_L2; end
      ST_SEND_L2: begin adv = xfer; target = ST_SEND_O;  end
      ST_SEND_O: begin
        adv    = xfer;
        target = (cnt_inc < rep_reg) ? ST_SEND_H : ST_IDLE;
        if (xfer) cnt_next = cnt_inc;
      end
      ST_GAP: begin
        if (gap_zero) begin
          state_next = ret_reg;
          done_next  = (ret_reg == ST_IDLE);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (adv) begin
      if (GAP_CYCLES == 0) begin
        state_next = target;
        done_next  = (target == ST_IDLE);
      end else begin
        state_next = ST_GAP;
        ret_next   = target;
        gap_load   = 1'b1;
      end
    end

    // Outputs are registered copies of what the next state presents.
    valid_next = is_send(state_next);
    data_next  = char_of(state_next);
    busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ret_reg   <= ST_IDLE;
      rep_reg   <= '0;
      cnt_reg   <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ret_reg   <= ret_next;
      rep_reg   <= rep_next;
      cnt_reg   <= cnt_next;
      data      <= data_next;
      valid     <= valid_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_fsm_hello_tx.sv
// Directed self-checking bench for fsm_hello_tx (no-gap and two-cycle-gap builds).
module tb_fsm_hello_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start2 = 1'b0;
  logic       ready = 1'b1;
  logic [3:0] repeat_n = 4'd1;
  logic [7:0] data0, data2;
  logic       valid0, busy0, done0, valid2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic [7:0]  word_b [5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
  logic [31:0] det_hist;
  logic        led;
  int          led_toggles;

  always #5 clk = ~clk;

  fsm_hello_tx #(.GAP_CYCLES(0), .REPEAT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .repeat_n(repeat_n),
    .data(data0), .valid(valid0), .ready(ready), .busy(busy0), .done(done0)
  );

  fsm_hello_tx #(.GAP_CYCLES(2), .REPEAT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .repeat_n(repeat_n),
    .data(data2), .valid(valid2), .ready(ready), .busy(busy2), .done(done2)
  );

  // Behavioural loopback detector: led toggles on every complete "Hello".
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      det_hist    <= 32'h0;
      led         <= 1'b0;
      led_toggles <= 0;
    end else if (valid0 && ready) begin
      det_hist <= {det_hist[23:0], data0};
      if ({det_hist, data0} == 40'h48656C6C6F) begin
        led         <= ~led;
        led_toggles <= led_toggles + 1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic out0(input string tag, input logic [7:0] d, input logic v, input logic b, input logic dn);
    $display("%s: data=%02h valid=%0b busy=%0b done=%0b", tag, data0, valid0, busy0, done0);
    chk({tag, " data"},  data0,        d);
    chk({tag, " valid"}, {7'd0, valid0}, {7'd0, v});
    chk({tag, " busy"},  {7'd0, busy0},  {7'd0, b});
    chk({tag, " done"},  {7'd0, done0},  {7'd0, dn});
  endtask

  task automatic out2(input string tag, input logic [7:0] d, input logic v, input logic b, input logic dn);
    $display("%s: data=%02h valid=%0b busy=%0b done=%0b", tag, data2, valid2, busy2, done2);
    chk({tag, " data"},  data2,        d);
    chk({tag, " valid"}, {7'd0, valid2}, {7'd0, v});
    chk({tag, " busy"},  {7'd0, busy2},  {7'd0, b});
    chk({tag, " done"},  {7'd0, done2},  {7'd0, dn});
  endtask

  // Leaves the bench at the negedge where 'H' should be presented.
  task automatic pulse_start0(input logic [3:0] n);
    start0   = 1'b1;
    repeat_n = n;
    tick();
    start0   = 1'b0;
  endtask

  task automatic expect_bytes(input string tag, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      out0($sformatf("%s_b%0d", tag, i), word_b[i % 5], 1'b1, 1'b1, 1'b0);
      tick();
    end
    out0({tag, "_done"}, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    out0({tag, "_idle"}, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    tick();
    out0("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    out2("reset2", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 1. Basic word
    pulse_start0(4'd1);
    expect_bytes("basic", 5);
    tick();

    // 2. Backpressure on 'e'
    pulse_start0(4'd1);
    out0("bp_h", 8'h48, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      out0($sformatf("bp_e%0d", i), 8'h65, 1'b1, 1'b1, 1'b0);
      ready = (i == 3);
      tick();
    end
    out0("bp_l1", 8'h6C, 1'b1, 1'b1, 1'b0);
    tick();
    out0("bp_l2", 8'h6C, 1'b1, 1'b1, 1'b0);
    tick();
    out0("bp_o", 8'h6F, 1'b1, 1'b1, 1'b0);
    tick();
    out0("bp_done", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();

    // 3. Repeat 3, repeat 0 treated as 1, maximum repeat 15
    pulse_start0(4'd3);
    expect_bytes("rep3", 15);
    tick();
    pulse_start0(4'd0);
    expect_bytes("rep0", 5);
    tick();
    pulse_start0(4'd15);
    expect_bytes("rep15", 75);
    tick();

    // 4. Two-cycle gap, two words
    start2   = 1'b1;
    repeat_n = 4'd2;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      out2($sformatf("gap_b%0d", i), word_b[i % 5], 1'b1, 1'b1, 1'b0);
      tick();
      out2($sformatf("gap_i%0da", i), 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      out2($sformatf("gap_i%0db", i), 8'h00, 1'b0, 1'b1, 1'b0);
      tick();
    end
    out2("gap_done", 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    out2("gap_idle", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();

    // 5. start mid-word ignored; start during done accepted; async reset
    pulse_start0(4'd1);
    out0("mid_h", 8'h48, 1'b1, 1'b1, 1'b0);
    tick();
    out0("mid_e", 8'h65, 1'b1, 1'b1, 1'b0);
    tick();
    out0("mid_l1", 8'h6C, 1'b1, 1'b1, 1'b0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    out0("mid_l2", 8'h6C, 1'b1, 1'b1, 1'b0);
    tick();
    out0("mid_o", 8'h6F, 1'b1, 1'b1, 1'b0);
    tick();
    out0("mid_done", 8'h00, 1'b0, 1'b0, 1'b1);
    pulse_start0(4'd1);
    out0("ondone_h", 8'h48, 1'b1, 1'b1, 1'b0);
    tick();
    out0("ondone_e", 8'h65, 1'b1, 1'b1, 1'b0);
    tick();
    out0("ondone_l1", 8'h6C, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 out0("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    out0("post_rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    out0("post_rst2", 8'h00, 1'b0, 1'b0, 1'b0);
    pulse_start0(4'd1);
    expect_bytes("restart", 5);

    // 6. Loopback into detector model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse_start0(4'd2);
    for (int i = 0; i < 10; i++) begin
      out0($sformatf("loop_b%0d", i), word_b[i % 5], 1'b1, 1'b1, 1'b0);
      if (i == 0) chk("loop_led_start", {7'd0, led}, 8'd0);
      if (i == 5) chk("loop_led_word1", {7'd0, led}, 8'd1);
      tick();
    end
    out0("loop_done", 8'h00, 1'b0, 1'b0, 1'b1);
    chk("loop_led_word2", {7'd0, led}, 8'd0);
    chk("loop_toggles", 8'(led_toggles), 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
